// File: rtl/accumulator_processor_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | accumulator_processor_pkg: opcodes, one-hot states, widths       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package accumulator_processor_pkg;

  localparam int DEFAULT_DATA_W = 32;

  localparam logic [1:0] c_op_nop   = 2'b00;
  localparam logic [1:0] c_op_fetch = 2'b01;
  localparam logic [1:0] c_op_send  = 2'b10;

  typedef enum logic [6:0] {
    c_st_req1 = 7'h01,
    c_st_reca = 7'h02,
    c_st_req2 = 7'h04,
    c_st_recb = 7'h08,
    c_st_add  = 7'h10,
    c_st_req3 = 7'h20,
    c_st_rslt = 7'h40
  } state_t;

  function automatic logic [1:0] op_for(input state_t s);
    case (s)
      c_st_reca, c_st_recb: op_for = c_op_fetch;
      c_st_rslt:            op_for = c_op_send;
      default:              op_for = c_op_nop;
    endcase
  endfunction

  function automatic logic req_for(input state_t s);
    req_for = (s != c_st_add);
  endfunction

endpackage
`default_nettype wire

// File: rtl/accumulator_processor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | accumulator_processor: fetches A and B over the bus, sends A+B   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module accumulator_processor
  import accumulator_processor_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        op,
  input  logic              signal,
  input  logic [DATA_W-1:0] read,
  output logic [DATA_W-1:0] write,
  output logic              req,
  input  logic              grant,
  output logic [6:0]        state
);

  state_t              r_state;
  state_t              w_next;
  logic                r_req;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_write;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_result;

  always_comb begin
    w_next = c_st_req1;
    case (r_state)
      c_st_req1: w_next = grant  ? c_st_reca : c_st_req1;
      c_st_reca: w_next = signal ? c_st_req2 : c_st_reca;
      c_st_req2: w_next = grant  ? c_st_recb : c_st_req2;
      c_st_recb: w_next = signal ? c_st_add  : c_st_recb;
      c_st_add:  w_next = c_st_req3;
      c_st_req3: w_next = grant  ? c_st_rslt : c_st_req3;
      c_st_rslt: w_next = signal ? c_st_req1 : c_st_rslt;
      default:   w_next = c_st_req1;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // still line up with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_st_req1;
      r_req    <= 1'b1;
      r_op     <= c_op_nop;
      r_write  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      r_req   <= req_for(w_next);
      r_op    <= op_for(w_next);
      r_write <= (w_next == c_st_rslt) ? r_result : '0;
      if (r_state == c_st_reca && signal) r_a <= read;
      if (r_state == c_st_recb && signal) r_b <= read;
      if (r_state == c_st_add)            r_result <= r_a + r_b;
    end
  end

  // The REQ1 decode would assert req during reset, so mask it with reset.
  assign req   = r_req & reset;
  assign op    = r_op;
  assign write = r_write;
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_accumulator_processor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_accumulator_processor: directed self-checking bench           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_accumulator_processor;

  logic        clk_tb = 1'b0;
  logic        reset;
  logic [1:0]  op;
  logic        signal;
  logic [31:0] read;
  logic [31:0] write;
  logic        req;
  logic        grant;
  logic [6:0]  state;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        g;
    logic        s;
    logic [31:0] r;
    logic [41:0] exp;  // {state, req, op, write}
  } step_t;

  accumulator_processor #(.DATA_W(32)) dut (
    .clk    (clk_tb),
    .reset  (reset),
    .op     (op),
    .signal (signal),
    .read   (read),
    .write  (write),
    .req    (req),
    .grant  (grant),
    .state  (state)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic step();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; grant = 1'b0; signal = 1'b0; read = '0;
    step();
    step();
    if ({state, req, op, write} !== {7'h01, 1'b0, 2'b00, 32'h0})
      $display("FAIL reset_hold: got %h exp %h", {state, req, op, write}, {7'h01, 1'b0, 2'b00, 32'h0});
    else passed++;
    total++;
    reset = 1'b1;
    #1;
    if ({state, req} !== {7'h01, 1'b1})
      $display("FAIL reset_release: got state=%h req=%b exp state=01 req=1", state, req);
    else passed++;
    total++;
  endtask

  // Runs one full accumulation from REQ1; optional 10-cycle stall in RECA
  // with grant high and junk on read, which must both be ignored.
  task automatic test_pass(input string name, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] sum,
                           input bit stall);
    step_t seq[$];
    seq.push_back('{1'b1, 1'b0, 32'h0, {7'h02, 1'b1, 2'b01, 32'h0}});
    if (stall)
      for (int i = 0; i < 10; i++)
        seq.push_back('{1'b1, 1'b0, 32'hDEAD_0000 + i, {7'h02, 1'b1, 2'b01, 32'h0}});
    seq.push_back('{1'b1, 1'b1, a,     {7'h04, 1'b1, 2'b00, 32'h0}});
    seq.push_back('{1'b1, 1'b0, 32'h0, {7'h08, 1'b1, 2'b01, 32'h0}});
    seq.push_back('{1'b0, 1'b1, b,     {7'h10, 1'b0, 2'b00, 32'h0}});
    seq.push_back('{1'b0, 1'b0, 32'h0, {7'h20, 1'b1, 2'b00, 32'h0}});
    seq.push_back('{1'b1, 1'b0, 32'h0, {7'h40, 1'b1, 2'b10, sum}});
    seq.push_back('{1'b0, 1'b0, 32'h0, {7'h40, 1'b1, 2'b10, sum}});
    seq.push_back('{1'b0, 1'b1, 32'h0, {7'h01, 1'b1, 2'b00, 32'h0}});
    foreach (seq[i]) begin
      grant = seq[i].g; signal = seq[i].s; read = seq[i].r;
      step();
      if ({state, req, op, write} !== seq[i].exp)
        $display("FAIL %s step%0d: got %h exp %h", name, i, {state, req, op, write}, seq[i].exp);
      else passed++;
      total++;
    end
    grant = 1'b0; signal = 1'b0; read = '0;
  endtask

  task automatic test_midop_reset();
    grant = 1'b1; step();
    grant = 1'b0; signal = 1'b1; read = 32'h0000_0100; step();
    signal = 1'b0; grant = 1'b1; step();
    grant = 1'b0;
    if (state !== 7'h08)
      $display("FAIL midop_reach_recb: got %h exp 08", state);
    else passed++;
    total++;
    #2 reset = 1'b0;
    #1;
    if ({state, req, op} !== {7'h01, 1'b0, 2'b00})
      $display("FAIL midop_async_reset: got %h exp %h", {state, req, op}, {7'h01, 1'b0, 2'b00});
    else passed++;
    total++;
    step();
    reset = 1'b1;
    test_pass("after_reset", 32'h7, 32'h8, 32'hF, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pass("full_pass", 32'h0000_1234, 32'h0000_0005, 32'h0000_1239, 1'b0);
    test_pass("overflow", 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0);
    test_pass("stall", 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b1);
    test_pass("back_to_back", 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1'b0);
    test_midop_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
